// File: rtl/id_ex_ctrl_pkg.sv
// Shared types and constants for the ID/EX sequencing controller.
// Provides FSM state encodings and register address width.
package id_ex_ctrl_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int CNT_WIDTH_DEF  = 32;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MWAIT = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/id_ex_ctrl_if.sv
// Handshake/status bundle between pipeline and sequencing controller.
// master: pipeline side (drives status), slave: controller (drives enables).
interface id_ex_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    import id_ex_ctrl_pkg::*;

    logic                      id_valid_i;
    logic [REG_ADDR_WIDTH-1:0] id_rs1_i;
    logic [REG_ADDR_WIDTH-1:0] id_rs2_i;
    logic                      id_rs1_used_i;
    logic                      id_rs2_used_i;
    logic                      ex_valid_i;
    logic [REG_ADDR_WIDTH-1:0] ex_rd_i;
    logic                      ex_reg_we_i;
    logic                      ex_is_load_i;
    logic                      ex_jump_i;
    logic                      ex_multi_i;
    logic                      ex_multi_done_i;
    logic                      mem_busy_i;
    logic                      pc_hold_o;
    logic                      if_id_hold_o;
    logic                      if_id_flush_o;
    logic                      id_ex_hold_o;
    logic                      id_ex_flush_o;
    logic [CNT_WIDTH-1:0]      stall_cnt_o;
    logic [CNT_WIDTH-1:0]      flush_cnt_o;

    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i,
        output id_rs1_used_i, id_rs2_used_i,
        output ex_valid_i, ex_rd_i, ex_reg_we_i,
        output ex_is_load_i, ex_jump_i,
        output ex_multi_i, ex_multi_done_i,
        output mem_busy_i,
        input  pc_hold_o, if_id_hold_o, if_id_flush_o,
        input  id_ex_hold_o, id_ex_flush_o,
        input  stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i,
        input  id_rs1_used_i, id_rs2_used_i,
        input  ex_valid_i, ex_rd_i, ex_reg_we_i,
        input  ex_is_load_i, ex_jump_i,
        input  ex_multi_i, ex_multi_done_i,
        input  mem_busy_i,
        output pc_hold_o, if_id_hold_o, if_id_flush_o,
        output id_ex_hold_o, id_ex_flush_o,
        output stall_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/id_ex_ctrl_hazard_det.sv
// Combinational load-use comparator (ID sources vs EX load destination).
// Ports: ID valid/rs1/rs2/used flags, EX valid/rd/we/load in; o_load_use out.
module id_ex_hazard_det
    import id_ex_ctrl_pkg::*;
(
    input  logic                      i_id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs2,
    input  logic                      i_rs1_used,
    input  logic                      i_rs2_used,
    input  logic                      i_ex_valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_ex_rd,
    input  logic                      i_ex_we,
    input  logic                      i_ex_load,
    output logic                      o_load_use
);

    logic w_ex_ld;
    logic w_m1;
    logic w_m2;

    // x0 is never a real dependency
    assign w_ex_ld = i_ex_valid & i_ex_load & i_ex_we
                   & (i_ex_rd != '0);
    assign w_m1 = i_rs1_used & (i_rs1 == i_ex_rd);
    assign w_m2 = i_rs2_used & (i_rs2 == i_ex_rd);

    assign o_load_use = i_id_valid & w_ex_ld & (w_m1 | w_m2);

endmodule

// File: rtl/id_ex_ctrl.sv
// ID/EX sequencing controller: load-use stall, multi-cycle/bus freeze,
// jump flush; clk/rst plain ports, everything else on bus (slave).
module id_ex_ctrl
    import id_ex_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_WIDTH    = 32
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_ctrl_if.slave  bus
);

    state_t               r_state;
    logic [2:0]           r_left;
    logic [CNT_WIDTH-1:0] r_stall;
    logic [CNT_WIDTH-1:0] r_flush;

    state_t     w_next;
    logic [2:0] w_next_left;
    logic       w_flush_evt;
    logic       w_load_use;
    logic       w_pc_hold;
    logic       w_ifid_hold;
    logic       w_ifid_flush;
    logic       w_idex_hold;
    logic       w_idex_flush;

    id_ex_hazard_det u_hz (
        .i_id_valid (bus.id_valid_i),
        .i_rs1      (bus.id_rs1_i),
        .i_rs2      (bus.id_rs2_i),
        .i_rs1_used (bus.id_rs1_used_i),
        .i_rs2_used (bus.id_rs2_used_i),
        .i_ex_valid (bus.ex_valid_i),
        .i_ex_rd    (bus.ex_rd_i),
        .i_ex_we    (bus.ex_reg_we_i),
        .i_ex_load  (bus.ex_is_load_i),
        .o_load_use (w_load_use)
    );

    always_comb begin
        w_next       = r_state;
        w_next_left  = r_left;
        w_flush_evt  = 1'b0;
        w_pc_hold    = 1'b0;
        w_ifid_hold  = 1'b0;
        w_ifid_flush = 1'b0;
        w_idex_hold  = 1'b0;
        w_idex_flush = 1'b0;
        if (rst) begin
            // bubbles into both registers while in reset
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (bus.mem_busy_i) begin
                        w_pc_hold   = 1'b1;
                        w_ifid_hold = 1'b1;
                        w_idex_hold = 1'b1;
                    end else if (bus.ex_valid_i && bus.ex_multi_i) begin
                        w_pc_hold   = 1'b1;
                        w_ifid_hold = 1'b1;
                        w_idex_hold = 1'b1;
                        w_next      = ST_MWAIT;
                    end else if (bus.ex_valid_i && bus.ex_jump_i) begin
                        w_ifid_flush = 1'b1;
                        w_idex_flush = 1'b1;
                        w_flush_evt  = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            w_next      = ST_FLUSH;
                            w_next_left = 3'(FLUSH_CYCLES - 1);
                        end
                    end else if (w_load_use) begin
                        w_pc_hold    = 1'b1;
                        w_ifid_hold  = 1'b1;
                        w_idex_flush = 1'b1;
                    end
                end
                ST_MWAIT: begin
                    if (bus.ex_multi_done_i && !bus.mem_busy_i) begin
                        w_next = ST_RUN;
                    end else begin
                        w_pc_hold   = 1'b1;
                        w_ifid_hold = 1'b1;
                        w_idex_hold = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                    if (bus.mem_busy_i) begin
                        w_pc_hold = 1'b1;
                    end else begin
                        w_next_left = r_left - 3'd1;
                        if (r_left == 3'd1) begin
                            w_next = ST_RUN;
                        end
                    end
                end
                default: begin
                    w_next = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_left  <= 3'd0;
            r_stall <= '0;
            r_flush <= '0;
        end else begin
            r_state <= w_next;
            r_left  <= w_next_left;
            if (w_pc_hold) begin
                r_stall <= r_stall + 1'b1;
            end
            if (w_flush_evt) begin
                r_flush <= r_flush + 1'b1;
            end
        end
    end

    assign bus.pc_hold_o     = w_pc_hold;
    assign bus.if_id_hold_o  = w_ifid_hold;
    assign bus.if_id_flush_o = w_ifid_flush;
    assign bus.id_ex_hold_o  = w_idex_hold;
    assign bus.id_ex_flush_o = w_idex_flush;
    assign bus.stall_cnt_o   = r_stall;
    assign bus.flush_cnt_o   = r_flush;

endmodule

// File: tb/tb_id_ex_ctrl.sv
// Bench for id_ex_ctrl: two instances (FLUSH_CYCLES=2 and 3) driven alike.
// Directed scenarios plus randomized traffic against a reference model.
module tb_id_ex_ctrl;

    logic clk;
    logic rst;

    id_ex_ctrl_if #(.CNT_WIDTH(32)) if0 ();
    id_ex_ctrl_if #(.CNT_WIDTH(32)) if1 ();

    id_ex_ctrl #(.FLUSH_CYCLES(2), .CNT_WIDTH(32)) u0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    id_ex_ctrl #(.FLUSH_CYCLES(3), .CNT_WIDTH(32)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // stimulus
    logic       s_rst;
    logic       s_idv, s_u1, s_u2, s_exv, s_we, s_ld;
    logic       s_jmp, s_mul, s_done, s_busy;
    logic [4:0] s_rs1, s_rs2, s_rd;

    // out vector order: {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush}
    logic [4:0]  d_out [2];
    logic [31:0] d_st  [2];
    logic [31:0] d_fl  [2];

    assign d_out[0] = {if0.pc_hold_o, if0.if_id_hold_o, if0.if_id_flush_o,
                       if0.id_ex_hold_o, if0.id_ex_flush_o};
    assign d_out[1] = {if1.pc_hold_o, if1.if_id_hold_o, if1.if_id_flush_o,
                       if1.id_ex_hold_o, if1.id_ex_flush_o};
    assign d_st[0] = if0.stall_cnt_o;
    assign d_st[1] = if1.stall_cnt_o;
    assign d_fl[0] = if0.flush_cnt_o;
    assign d_fl[1] = if1.flush_cnt_o;

    // reference model: remaining flush cycles and multi-cycle wait flag
    int          fc [2] = '{2, 3};
    bit          m_mw [2];
    int          m_left [2];
    logic [31:0] m_st [2];
    logic [31:0] m_fl [2];
    logic [4:0]  e_out [2];
    logic [31:0] e_st [2];
    logic [31:0] e_fl [2];

    task automatic idle_inputs();
        s_rst = 0; s_idv = 0; s_u1 = 0; s_u2 = 0; s_exv = 0;
        s_we = 0; s_ld = 0; s_jmp = 0; s_mul = 0; s_done = 0;
        s_busy = 0; s_rs1 = 0; s_rs2 = 0; s_rd = 0;
    endtask

    task automatic drive_if();
        rst = s_rst;
        if0.id_valid_i = s_idv;      if1.id_valid_i = s_idv;
        if0.id_rs1_i = s_rs1;        if1.id_rs1_i = s_rs1;
        if0.id_rs2_i = s_rs2;        if1.id_rs2_i = s_rs2;
        if0.id_rs1_used_i = s_u1;    if1.id_rs1_used_i = s_u1;
        if0.id_rs2_used_i = s_u2;    if1.id_rs2_used_i = s_u2;
        if0.ex_valid_i = s_exv;      if1.ex_valid_i = s_exv;
        if0.ex_rd_i = s_rd;          if1.ex_rd_i = s_rd;
        if0.ex_reg_we_i = s_we;      if1.ex_reg_we_i = s_we;
        if0.ex_is_load_i = s_ld;     if1.ex_is_load_i = s_ld;
        if0.ex_jump_i = s_jmp;       if1.ex_jump_i = s_jmp;
        if0.ex_multi_i = s_mul;      if1.ex_multi_i = s_mul;
        if0.ex_multi_done_i = s_done; if1.ex_multi_done_i = s_done;
        if0.mem_busy_i = s_busy;     if1.mem_busy_i = s_busy;
    endtask

    // one cycle: apply inputs, settle, compute expectations, model steps
    task automatic tick();
        bit lu;
        @(negedge clk);
        drive_if();
        #1;
        lu = s_idv && s_exv && s_ld && s_we && (s_rd != 0) &&
             ((s_u1 && s_rs1 == s_rd) || (s_u2 && s_rs2 == s_rd));
        for (int k = 0; k < 2; k++) begin
            e_st[k] = m_st[k];
            e_fl[k] = m_fl[k];
            if (s_rst) begin
                e_out[k] = 5'b00101;
                m_mw[k] = 0; m_left[k] = 0;
                m_st[k] = 0; m_fl[k] = 0;
            end else begin
                if (m_mw[k]) begin
                    if (s_done && !s_busy) begin
                        e_out[k] = 5'b00000;
                        m_mw[k] = 0;
                    end else begin
                        e_out[k] = 5'b11010;
                    end
                end else if (m_left[k] > 0) begin
                    if (s_busy) begin
                        e_out[k] = 5'b10101;
                    end else begin
                        e_out[k] = 5'b00101;
                        m_left[k]--;
                    end
                end else if (s_busy) begin
                    e_out[k] = 5'b11010;
                end else if (s_exv && s_mul) begin
                    e_out[k] = 5'b11010;
                    m_mw[k] = 1;
                end else if (s_exv && s_jmp) begin
                    e_out[k] = 5'b00101;
                    m_fl[k]++;
                    m_left[k] = fc[k] - 1;
                end else if (lu) begin
                    e_out[k] = 5'b11001;
                end else begin
                    e_out[k] = 5'b00000;
                end
                if (e_out[k][4]) m_st[k]++;
            end
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        s_rst = 1;
        tick();
        s_rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (d_out[k] !== 5'b00101) begin
                n_err++;
                $display("FAIL reset_out dut%0d got %b want 00101", k, d_out[k]);
            end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (d_out[k] !== 5'b00000 || d_st[k] !== 0 || d_fl[k] !== 0) begin
                n_err++;
                $display("FAIL reset_idle dut%0d got %b/%0d/%0d want 00000/0/0",
                         k, d_out[k], d_st[k], d_fl[k]);
            end
        end
    endtask

    task automatic test_load_use();
        do_reset();
        s_exv = 1; s_rd = 5; s_ld = 1; s_we = 1;
        s_idv = 1; s_rs1 = 5; s_u1 = 1; s_rs2 = 7; s_u2 = 1;
        tick();
        n_vec++;
        if (d_out[0] !== 5'b11001) begin
            n_err++;
            $display("FAIL load_use got %b want 11001", d_out[0]);
        end
        s_exv = 0;
        tick();
        n_vec++;
        if (d_out[0] !== 5'b00000 || d_st[0] !== 1) begin
            n_err++;
            $display("FAIL load_use_after got %b/%0d want 00000/1", d_out[0], d_st[0]);
        end
    endtask

    task automatic test_no_false_hazard();
        do_reset();
        s_exv = 1; s_rd = 0; s_ld = 1; s_we = 1;
        s_idv = 1; s_rs1 = 0; s_u1 = 1;
        tick();
        n_vec++;
        if (d_out[0] !== 5'b00000) begin
            n_err++;
            $display("FAIL no_haz_x0 got %b want 00000", d_out[0]);
        end
        s_rd = 9; s_rs1 = 3; s_rs2 = 9; s_u2 = 0;
        tick();
        n_vec++;
        if (d_out[0] !== 5'b00000) begin
            n_err++;
            $display("FAIL no_haz_rs2_unused got %b want 00000", d_out[0]);
        end
        s_u2 = 1;
        tick();
        n_vec++;
        if (d_out[0] !== 5'b11001) begin
            n_err++;
            $display("FAIL haz_rs2 got %b want 11001", d_out[0]);
        end
    endtask

    task automatic test_multi();
        do_reset();
        s_exv = 1; s_mul = 1;
        for (int c = 1; c <= 5; c++) begin
            s_done = (c == 5);
            tick();
            n_vec++;
            if (d_out[1] !== ((c < 5) ? 5'b11010 : 5'b00000)) begin
                n_err++;
                $display("FAIL multi_c%0d got %b want %b", c, d_out[1],
                         (c < 5) ? 5'b11010 : 5'b00000);
            end
        end
        idle_inputs();
        tick();
        n_vec++;
        if (d_out[1] !== 5'b00000 || d_st[1] !== 4) begin
            n_err++;
            $display("FAIL multi_end got %b/%0d want 00000/4", d_out[1], d_st[1]);
        end
    endtask

    task automatic test_jump();
        do_reset();
        s_exv = 1; s_jmp = 1;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (d_out[k] !== 5'b00101) begin
                n_err++;
                $display("FAIL jump_c2 dut%0d got %b want 00101", k, d_out[k]);
            end
        end
        idle_inputs();
        tick();
        n_vec++;
        if (d_out[0] !== 5'b00000 || d_fl[0] !== 1) begin
            n_err++;
            $display("FAIL jump_end got %b/%0d want 00000/1", d_out[0], d_fl[0]);
        end
        n_vec++;
        if (d_out[1] !== 5'b00101) begin
            n_err++;
            $display("FAIL jump_fc3_c3 got %b want 00101", d_out[1]);
        end
    endtask

    task automatic test_busy_flush();
        logic [4:0] want [6];
        want = '{5'b00101, 5'b10101, 5'b10101, 5'b00101, 5'b00101, 5'b00000};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            idle_inputs();
            if (c == 0) begin s_exv = 1; s_jmp = 1; end
            if (c == 1 || c == 2) s_busy = 1;
            tick();
            n_vec++;
            if (d_out[1] !== want[c]) begin
                n_err++;
                $display("FAIL busy_flush_c%0d got %b want %b", c, d_out[1], want[c]);
            end
        end
        n_vec++;
        if (d_st[1] !== 2 || d_fl[1] !== 1) begin
            n_err++;
            $display("FAIL busy_flush_cnt got %0d/%0d want 2/1", d_st[1], d_fl[1]);
        end
    endtask

    task automatic test_reset_mwait();
        do_reset();
        s_exv = 1; s_mul = 1;
        tick();
        tick();
        s_rst = 1;
        tick();
        n_vec++;
        if (d_out[0] !== 5'b00101) begin
            n_err++;
            $display("FAIL rst_mwait got %b want 00101", d_out[0]);
        end
        idle_inputs();
        tick();
        n_vec++;
        if (d_out[0] !== 5'b00000 || d_st[0] !== 0 || d_fl[0] !== 0) begin
            n_err++;
            $display("FAIL rst_mwait_after got %b/%0d/%0d want 00000/0/0",
                     d_out[0], d_st[0], d_fl[0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            s_rst  = ($urandom_range(63) == 0);
            s_idv  = $urandom_range(3) != 0;
            s_u1   = $urandom_range(1) != 0;
            s_u2   = $urandom_range(1) != 0;
            s_rs1  = 5'($urandom_range(3));
            s_rs2  = 5'($urandom_range(3));
            s_rd   = 5'($urandom_range(3));
            s_exv  = $urandom_range(3) != 0;
            s_we   = $urandom_range(3) != 0;
            s_ld   = $urandom_range(1) != 0;
            s_jmp  = $urandom_range(4) == 0;
            s_mul  = $urandom_range(5) == 0;
            s_done = $urandom_range(2) == 0;
            s_busy = $urandom_range(4) == 0;
            tick();
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (d_out[k] !== e_out[k] || d_st[k] !== e_st[k] ||
                    d_fl[k] !== e_fl[k]) begin
                    n_err++;
                    $display("FAIL rand_c%0d dut%0d got %b/%0d/%0d want %b/%0d/%0d",
                             c, k, d_out[k], d_st[k], d_fl[k],
                             e_out[k], e_st[k], e_fl[k]);
                end
            end
        end
    endtask

    initial begin
        idle_inputs();
        s_rst = 1;
        drive_if();
        for (int k = 0; k < 2; k++) begin
            m_mw[k] = 0; m_left[k] = 0; m_st[k] = 0; m_fl[k] = 0;
        end
        test_reset();
        test_load_use();
        test_no_false_hazard();
        test_multi();
        test_jump();
        test_busy_flush();
        test_reset_mwait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
